// File: rtl/sa_autosa_glb_csb_mst.sv
// CSB master: buffers host requests in a small FIFO, forwards them to the GEC,
// tracks how many responses the GEC still owes (and their read/write type),
// forwards GEC responses in order and synthesises error responses on timeout.
// Responses that arrive after their timeout has been reported are dropped.
module sa_autosa_glb_csb_mst #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OUTST  = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                             autosa_core_clk,
   input  logic                             autosa_core_rst,
   input  logic [62:0]                      host_req_pd,
   input  logic                             host_req_pvld,
   output logic                             host_req_prdy,
   output logic [62:0]                      csb2gec_req_pd,
   output logic                             csb2gec_req_pvld,
   input  logic                             csb2gec_req_prdy,
   input  logic [33:0]                      gec2csb_resp_pd,
   input  logic                             gec2csb_resp_valid,
   output logic [33:0]                      host_resp_pd,
   output logic                             host_resp_valid,
   output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt,
   output logic                             timeout_sticky,
   output logic                             unexp_sticky,
   input  logic                             sticky_clr
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W:0]   MAX_SUM   = (CNT_W + 1)'(MAX_OUTST);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

   logic [62:0]          fifo_mem_q [FIFO_DEPTH];
   logic [62:0]          fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       fifo_cnt_q, fifo_cnt_d;
   logic [MAX_OUTST-1:0] trk_q, trk_d, trk_shift_s;
   logic [CNT_W-1:0]     outst_q, outst_d, drop_q, drop_d, trk_wr_idx_s;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [33:0]          resp_pd_q, resp_pd_d;
   logic                 tmo_sticky_q, tmo_sticky_d, unexp_sticky_q, unexp_sticky_d;

   logic [62:0]          head_s;
   logic                 head_needs_resp_s, fifo_full_s, fifo_empty_s;
   logic [CNT_W:0]       owed_sum_s;
   logic                 acc_s, xfer_s, push_trk_s;
   logic                 drop_nz_s, outst_nz_s, drop_hit_s, fwd_s, unexp_s, tmo_s, pop_s;

   // Request-side handshakes: FIFO flags, head decode and the GEC issue gate.
   always_comb begin
      fifo_full_s       = (fifo_cnt_q == FIFO_FULL);
      fifo_empty_s      = (fifo_cnt_q == {(PTR_W + 1){1'b0}});
      head_s            = fifo_mem_q[rd_ptr_q];
      // reads and non-posted writes both owe a response
      head_needs_resp_s = ~head_s[54] | head_s[55];
      owed_sum_s        = {1'b0, outst_q} + {1'b0, drop_q};
      host_req_prdy     = ~autosa_core_rst & ~fifo_full_s;
      // the owed sum never rises without a transfer, so pvld cannot drop before it
      csb2gec_req_pvld  = ~autosa_core_rst & ~fifo_empty_s &
                          (~head_needs_resp_s | (owed_sum_s < MAX_SUM));
      csb2gec_req_pd    = head_s;
      acc_s             = host_req_pvld & host_req_prdy;
      xfer_s            = csb2gec_req_pvld & csb2gec_req_prdy;
      push_trk_s        = xfer_s & head_needs_resp_s;
   end

   // Response-side event decode; a real response always beats a timeout.
   always_comb begin
      drop_nz_s  = (drop_q != {CNT_W{1'b0}});
      outst_nz_s = (outst_q != {CNT_W{1'b0}});
      drop_hit_s = gec2csb_resp_valid & drop_nz_s;
      fwd_s      = gec2csb_resp_valid & ~drop_nz_s & outst_nz_s;
      unexp_s    = gec2csb_resp_valid & ~drop_nz_s & ~outst_nz_s;
      tmo_s      = ~gec2csb_resp_valid & outst_nz_s & (timer_q == TMR_LAST);
      pop_s      = fwd_s | tmo_s;
   end

   // Request FIFO next state.
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      if (acc_s) begin
         fifo_mem_d[wr_ptr_q] = host_req_pd;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (xfer_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({acc_s, xfer_s})
         2'b10:   fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - (PTR_W + 1)'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // Type tracker (oldest at bit 0), owed/drop counters and the wait timer.
   always_comb begin
      trk_shift_s  = pop_s ? (trk_q >> 1'b1) : trk_q;
      trk_wr_idx_s = outst_q - CNT_W'(pop_s);
      for (int i = 0; i < MAX_OUTST; i++) begin
         if (push_trk_s && (trk_wr_idx_s == CNT_W'(i))) begin
            trk_d[i] = head_s[54];
         end else begin
            trk_d[i] = trk_shift_s[i];
         end
      end
      case ({push_trk_s, pop_s})
         2'b10:   outst_d = outst_q + CNT_W'(1);
         2'b01:   outst_d = outst_q - CNT_W'(1);
         default: outst_d = outst_q;
      endcase
      if (tmo_s) begin
         drop_d = drop_q + CNT_W'(1);
      end else if (drop_hit_s) begin
         drop_d = drop_q - CNT_W'(1);
      end else begin
         drop_d = drop_q;
      end
      // timer holds at its last value if a dropped response masks an expiry
      if (!outst_nz_s || pop_s) begin
         timer_d = {TMR_W{1'b0}};
      end else if (timer_q == TMR_LAST) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + TMR_W'(1);
      end
   end

   // Host response register and sticky flags (set wins over clear).
   always_comb begin
      resp_valid_d = pop_s;
      if (fwd_s) begin
         resp_pd_d = gec2csb_resp_pd;
      end else if (tmo_s) begin
         resp_pd_d = {trk_q[0], 1'b1, 32'h0000_0000};
      end else begin
         resp_pd_d = resp_pd_q;
      end
      if (tmo_s) begin
         tmo_sticky_d = 1'b1;
      end else if (sticky_clr) begin
         tmo_sticky_d = 1'b0;
      end else begin
         tmo_sticky_d = tmo_sticky_q;
      end
      if (unexp_s) begin
         unexp_sticky_d = 1'b1;
      end else if (sticky_clr) begin
         unexp_sticky_d = 1'b0;
      end else begin
         unexp_sticky_d = unexp_sticky_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge autosa_core_clk) begin
      if (autosa_core_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= 63'd0;
         end
         wr_ptr_q       <= {PTR_W{1'b0}};
         rd_ptr_q       <= {PTR_W{1'b0}};
         fifo_cnt_q     <= {(PTR_W + 1){1'b0}};
         trk_q          <= {MAX_OUTST{1'b0}};
         outst_q        <= {CNT_W{1'b0}};
         drop_q         <= {CNT_W{1'b0}};
         timer_q        <= {TMR_W{1'b0}};
         resp_valid_q   <= 1'b0;
         resp_pd_q      <= 34'd0;
         tmo_sticky_q   <= 1'b0;
         unexp_sticky_q <= 1'b0;
      end else begin
         fifo_mem_q     <= fifo_mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fifo_cnt_q     <= fifo_cnt_d;
         trk_q          <= trk_d;
         outst_q        <= outst_d;
         drop_q         <= drop_d;
         timer_q        <= timer_d;
         resp_valid_q   <= resp_valid_d;
         resp_pd_q      <= resp_pd_d;
         tmo_sticky_q   <= tmo_sticky_d;
         unexp_sticky_q <= unexp_sticky_d;
      end
   end

   assign host_resp_valid = resp_valid_q;
   assign host_resp_pd    = resp_pd_q;
   assign outst_cnt       = outst_q;
   assign timeout_sticky  = tmo_sticky_q;
   assign unexp_sticky    = unexp_sticky_q;

endmodule

// File: tb/tb_sa_autosa_glb_csb_mst.sv
// Bench for the CSB master: a queue-based model of requests, owed responses,
// drops and stickies is checked against the DUT every cycle, alongside
// directed scenarios with literal expectations.
module tb_sa_autosa_glb_csb_mst;
   localparam int FD = 4;
   localparam int MO = 4;
   localparam int TO = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [62:0] req_pd;
   logic        req_pvld;
   logic        req_prdy;
   logic [62:0] gec_pd;
   logic        gec_pvld;
   logic        gec_prdy;
   logic [33:0] resp_in_pd;
   logic        resp_in_valid;
   logic [33:0] host_pd;
   logic        host_valid;
   logic [2:0]  outst;
   logic        tsticky, usticky, sclr;

   int n_tests = 0;
   int n_fail  = 0;
   int dut_xfers = 0, dut_acc = 0, dut_resps = 0;

   sa_autosa_glb_csb_mst #(.FIFO_DEPTH(FD), .MAX_OUTST(MO), .TIMEOUT(TO)) dut (
      .autosa_core_clk(clk), .autosa_core_rst(rst),
      .host_req_pd(req_pd), .host_req_pvld(req_pvld), .host_req_prdy(req_prdy),
      .csb2gec_req_pd(gec_pd), .csb2gec_req_pvld(gec_pvld), .csb2gec_req_prdy(gec_prdy),
      .gec2csb_resp_pd(resp_in_pd), .gec2csb_resp_valid(resp_in_valid),
      .host_resp_pd(host_pd), .host_resp_valid(host_valid),
      .outst_cnt(outst), .timeout_sticky(tsticky), .unexp_sticky(usticky),
      .sticky_clr(sclr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [62:0] mk(input logic [21:0] a, input logic [31:0] d,
                                      input logic w, input logic np);
      return {2'b00, 4'hF, 1'b0, np, w, d, a};
   endfunction

   function automatic logic needs(input logic [62:0] r);
      return !r[54] || r[55];
   endfunction

   // ---------------- behavioural model ----------------
   logic [62:0] m_fifo[$];
   logic        m_owed[$];
   int          m_drop = 0, m_timer = 0;
   logic        m_ts = 1'b0, m_us = 1'b0, m_rvalid = 1'b0;
   logic [33:0] m_rpd = 34'd0;
   bit          m_started = 1'b0;

   function automatic logic m_pvld();
      return !rst && (m_fifo.size() > 0) &&
             (!needs(m_fifo[0]) || ((m_owed.size() + m_drop) < MO));
   endfunction

   task automatic model_step();
      bit xfer, acc, popped, tset, uset;
      int owed_before;
      logic [62:0] hd;
      if (rst) begin
         m_fifo.delete(); m_owed.delete();
         m_drop = 0; m_timer = 0; m_ts = 1'b0; m_us = 1'b0;
         m_rvalid = 1'b0; m_rpd = 34'd0; m_started = 1'b1;
         return;
      end
      xfer = m_pvld() && gec_prdy;
      acc  = req_pvld && (m_fifo.size() < FD);
      owed_before = m_owed.size();
      popped = 1'b0; tset = 1'b0; uset = 1'b0; m_rvalid = 1'b0;
      if (resp_in_valid) begin
         if (m_drop > 0) m_drop--;
         else if (owed_before > 0) begin
            m_rvalid = 1'b1; m_rpd = resp_in_pd;
            void'(m_owed.pop_front()); popped = 1'b1;
         end else uset = 1'b1;
      end else if (owed_before > 0 && m_timer == TO - 1) begin
         m_rvalid = 1'b1; m_rpd = {m_owed[0], 1'b1, 32'h0};
         void'(m_owed.pop_front()); popped = 1'b1;
         m_drop++; tset = 1'b1;
      end
      if (owed_before == 0 || popped) m_timer = 0;
      else if (m_timer < TO - 1) m_timer++;
      if (xfer) begin
         hd = m_fifo.pop_front();
         if (needs(hd)) m_owed.push_back(hd[54]);
      end
      if (acc) m_fifo.push_back(req_pd);
      if (tset) m_ts = 1'b1; else if (sclr) m_ts = 1'b0;
      if (uset) m_us = 1'b1; else if (sclr) m_us = 1'b0;
   endtask

   // Compare process: advance the model on each edge, check the DUT just after.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (m_started) begin
            chk("m_prdy", req_prdy, !rst && (m_fifo.size() < FD));
            chk("m_pvld", gec_pvld, m_pvld());
            if (m_pvld()) chk("m_reqpd", gec_pd, m_fifo[0]);
            chk("m_rvalid", host_valid, m_rvalid);
            chk("m_rpd", host_pd, m_rpd);
            chk("m_outst", outst, m_owed.size());
            chk("m_tsticky", tsticky, m_ts);
            chk("m_usticky", usticky, m_us);
         end
      end
   end

   // Event counters sampled from the DUT at each edge.
   always @(posedge clk) begin
      dut_xfers <= dut_xfers + ((gec_pvld === 1'b1 && gec_prdy === 1'b1) ? 1 : 0);
      dut_acc   <= dut_acc + ((req_pvld === 1'b1 && req_prdy === 1'b1) ? 1 : 0);
      dut_resps <= dut_resps + ((host_valid === 1'b1) ? 1 : 0);
   end

   task automatic send(input logic [62:0] pd);
      int k;
      req_pd = pd; req_pvld = 1'b1; k = 0;
      while (req_prdy !== 1'b1 && k < 50) begin
         @(negedge clk); k++;
      end
      chk("send_bound", (k < 50), 1'b1);
      @(negedge clk);
      req_pvld = 1'b0;
   endtask

   task automatic wait_host_resp(input int lim);
      int k;
      k = 0;
      while (host_valid !== 1'b1 && k < lim) begin
         @(negedge clk); k++;
      end
      chk("resp_bound", host_valid, 1'b1);
   endtask

   task automatic gec_resp(input logic [33:0] pd);
      resp_in_pd = pd; resp_in_valid = 1'b1;
      @(negedge clk);
      resp_in_valid = 1'b0;
   endtask

   // Directed stimulus.
   initial begin
      int x0, a0, r0, k;
      rst = 1'b1; req_pd = 63'd0; req_pvld = 1'b0; gec_prdy = 1'b0;
      resp_in_pd = 34'd0; resp_in_valid = 1'b0; sclr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_prdy", req_prdy, 1'b0);
      chk("rst_pvld", gec_pvld, 1'b0);
      chk("rst_rvalid", host_valid, 1'b0);
      chk("rst_rpd", host_pd, 34'd0);
      chk("rst_outst", outst, 3'd0);
      rst = 1'b0; gec_prdy = 1'b1;
      @(negedge clk);
      chk("rel_prdy", req_prdy, 1'b1);

      // single read, answered
      req_pd = mk(22'h10, 32'h0, 1'b0, 1'b0); req_pvld = 1'b1;
      @(negedge clk);
      req_pvld = 1'b0;
      chk("rd_pvld", gec_pvld, 1'b1);
      chk("rd_pd", gec_pd, mk(22'h10, 32'h0, 1'b0, 1'b0));
      @(negedge clk);
      chk("rd_outst1", outst, 3'd1);
      gec_resp({1'b0, 1'b0, 32'hA5A5_A5A5});
      chk("rd_rvalid", host_valid, 1'b1);
      chk("rd_rpd", host_pd, 34'h0_A5A5_A5A5);
      chk("rd_outst0", outst, 3'd0);
      @(negedge clk);
      chk("rd_pulse", host_valid, 1'b0);
      chk("rd_hold", host_pd, 34'h0_A5A5_A5A5);

      // posted write: forwarded, no response owed
      x0 = dut_xfers; r0 = dut_resps;
      send(mk(22'h20, 32'hDEAD_BEEF, 1'b1, 1'b0));
      repeat (4) @(negedge clk);
      chk("pw_xfer", dut_xfers - x0, 1);
      chk("pw_outst", outst, 3'd0);
      chk("pw_noresp", dut_resps - r0, 0);

      // response arriving in the very cycle the timer expires wins
      send(mk(22'h30, 32'h0, 1'b0, 1'b0));
      k = 0;
      while (outst !== 3'd1 && k < 20) begin
         @(negedge clk); k++;
      end
      chk("race_bound", outst, 3'd1);
      repeat (TO - 1) @(negedge clk);
      gec_resp({1'b0, 1'b0, 32'h1234_5678});
      chk("race_rvalid", host_valid, 1'b1);
      chk("race_rpd", host_pd, 34'h0_1234_5678);
      chk("race_nosticky", tsticky, 1'b0);
      repeat (3) @(negedge clk);
      chk("race_noerr", host_valid, 1'b0);

      // outstanding limit: five reads, four go out
      x0 = dut_xfers;
      for (int i = 0; i < 5; i++) send(mk(22'h100 + 22'(i), 32'h0, 1'b0, 1'b0));
      repeat (6) @(negedge clk);
      chk("mo_xfers4", dut_xfers - x0, 4);
      chk("mo_pvld0", gec_pvld, 1'b0);
      chk("mo_outst4", outst, 3'd4);
      gec_resp({1'b0, 1'b0, 32'h0000_0001});
      chk("mo_rvalid", host_valid, 1'b1);
      @(negedge clk);
      chk("mo_xfers5", dut_xfers - x0, 5);
      for (int i = 0; i < 4; i++) begin
         gec_resp({1'b0, 1'b0, 32'h0000_0100 + 32'(i)});
         @(negedge clk);
      end
      chk("mo_drain", outst, 3'd0);

      // read timeout, then its late response is dropped
      send(mk(22'h200, 32'h0, 1'b0, 1'b0));
      wait_host_resp(3 * TO);
      chk("to_rd_pd", host_pd, 34'h1_0000_0000);
      chk("to_sticky", tsticky, 1'b1);
      @(negedge clk);
      gec_resp({1'b0, 1'b0, 32'hBAD0_0001});
      chk("drop_noresp", host_valid, 1'b0);
      chk("drop_nounexp", usticky, 1'b0);

      // non-posted write timeout carries type 1
      send(mk(22'h204, 32'hCAFE_F00D, 1'b1, 1'b1));
      wait_host_resp(3 * TO);
      chk("to_wr_pd", host_pd, 34'h3_0000_0000);
      @(negedge clk);
      gec_resp({1'b1, 1'b0, 32'h0});
      chk("drop2_noresp", host_valid, 1'b0);

      // with the drop count back to 0, a stray response is unexpected
      gec_resp({1'b0, 1'b0, 32'h5555_5555});
      chk("unexp_noresp", host_valid, 1'b0);
      chk("unexp_set", usticky, 1'b1);
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
      chk("clr_t", tsticky, 1'b0);
      chk("clr_u", usticky, 1'b0);
      // set beats clear in the same cycle
      sclr = 1'b1;
      gec_resp({1'b0, 1'b0, 32'h6666_6666});
      sclr = 1'b0;
      chk("prio_u", usticky, 1'b1);

      // fill the FIFO against a stalled GEC with one response owed, then reset
      send(mk(22'h300, 32'h0, 1'b0, 1'b0));
      repeat (2) @(negedge clk);
      gec_prdy = 1'b0;
      a0 = dut_acc;
      for (int i = 0; i < 8; i++) begin
         req_pd = mk(22'h400 + 22'(i), 32'(i), 1'b1, 1'b0); req_pvld = 1'b1;
         @(negedge clk);
      end
      req_pvld = 1'b0;
      chk("fill_acc", dut_acc - a0, 4);
      chk("fill_prdy", req_prdy, 1'b0);
      chk("fill_outst", outst, 3'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_prdy", req_prdy, 1'b0);
      chk("mrst_pvld", gec_pvld, 1'b0);
      chk("mrst_rvalid", host_valid, 1'b0);
      chk("mrst_rpd", host_pd, 34'd0);
      chk("mrst_outst", outst, 3'd0);
      chk("mrst_t", tsticky, 1'b0);
      chk("mrst_u", usticky, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_prdy", req_prdy, 1'b1);
      chk("post_pvld", gec_pvld, 1'b0);

      // normal operation resumes
      gec_prdy = 1'b1;
      send(mk(22'h3F_FFFF, 32'h0, 1'b0, 1'b0));
      @(negedge clk);
      gec_resp({1'b0, 1'b1, 32'h0F0F_0F0F});
      chk("final_rpd", host_pd, 34'h1_0F0F_0F0F);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end
endmodule
